i2c_reg_writer: RTL and testbench

Write-only I2C master that performs one 3-byte register write (device address, register address, data) on the HDMI transmitter's configuration bus. It sits directly downstream of the I2C configuration sequencer. The sequencer presents one register/value pair per request and waits for `done`. This block owns the open-drain `i2c_serial_clock` and `i2c_serial_data` pins. It reports a missing acknowledge so the sequencer can retry.

---
 rtl/i2c_reg_writer.sv | 178 +++++++++++++++++
 tb/tb_i2c_reg_writer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_writer.sv
// i2c_reg_writer
//   Write-only I2C master. It issues a single 3-byte register write on the
//   HDMI transmitter configuration bus: START, device_addr, reg_addr,
//   reg_data, STOP. A NACK on any byte aborts the write with a STOP and
//   raises ack_error, so the upstream sequencer can retry.
//
// Ports
//   clock_50          system clock; all logic runs on its rising edge
//   reset             synchronous active-high reset
//   start             request strobe; sampled only while idle
//   device_addr       8-bit write address, R/W bit included
//   reg_addr          register address
//   reg_data          register value
//   busy              high while a transaction is in progress
//   done              one-cycle pulse at the end of each transaction
//   ack_error         a byte was NACKed; held until the next accepted start
//   i2c_serial_clock  SCL, open-drain (drives 0 or Z); never read back
//   i2c_serial_data   SDA, open-drain (drives 0 or Z)
module i2c_reg_writer #(
    parameter int CLK_HZ = 50_000_000,
    parameter int I2C_HZ = 100_000
) (
    input  logic       clock_50,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] device_addr,
    input  logic [7:0] reg_addr,
    input  logic [7:0] reg_data,
    output logic       busy,
    output logic       done,
    output logic       ack_error,
    inout  wire        i2c_serial_clock,
    inout  wire        i2c_serial_data
);
    // Clocks per quarter of an SCL period; must be at least 2.
    localparam int            Q      = CLK_HZ / (4 * I2C_HZ);
    localparam int            QW     = $clog2(Q);
    localparam logic [QW-1:0] Q_LAST = QW'(Q - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_BIT, S_STOP} state_t;

    state_t          state, n_state;
    logic [QW-1:0]   qcnt;
    logic [1:0]      quarter, n_quarter;
    logic [3:0]      bit_idx, n_bit_idx;    // 0..7 data bits, 8 = ACK slot
    logic [1:0]      byte_idx, n_byte_idx;  // 0 device, 1 register, 2 data
    logic            n_last;
    logic [2:0][7:0] tx_byte;
    logic            scl_low, sda_low;      // 1 = pull the line low
    logic            n_scl_low, n_sda_low;
    logic            tick;

    assign tick = (qcnt == Q_LAST);

    // Position and pin levels of the quarter that begins after this tick.
    // Registering the pins from the *next* position makes each pin change
    // appear in the first cycle of its quarter.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        n_state    = state;
        n_quarter  = quarter + 2'd1;
        n_bit_idx  = bit_idx;
        n_byte_idx = byte_idx;
        n_last     = 1'b0;
        n_scl_low  = 1'b0;
        n_sda_low  = 1'b0;

        if (quarter == 2'd3) begin
            case (state)
                S_START: begin
                    n_state    = S_BIT;
                    n_bit_idx  = 4'd0;
                    n_byte_idx = 2'd0;
                end
                S_BIT: begin
                    if (bit_idx != 4'd8) begin
                        n_bit_idx = bit_idx + 4'd1;
                    end else if (ack_error || byte_idx == 2'd2) begin
                        // NACK seen in q2 of this ACK slot, or last byte sent.
                        n_state = S_STOP;
                    end else begin
                        n_bit_idx  = 4'd0;
                        n_byte_idx = byte_idx + 2'd1;
                    end
                end
                S_STOP: begin
                    n_state = S_IDLE;
                    n_last  = 1'b1;
                end
                default: ;
            endcase
        end

        case (n_state)
            S_START: begin
                n_sda_low = (n_quarter != 2'd0);
                n_scl_low = (n_quarter == 2'd3);
            end
            S_BIT: begin
                n_scl_low = ~n_quarter[1];
                // The ACK slot releases SDA so the slave can answer.
                n_sda_low = (n_bit_idx != 4'd8) &&
                            !tx_byte[n_byte_idx][3'd7 - n_bit_idx[2:0]];
            end
            S_STOP: begin
                n_scl_low = (n_quarter == 2'd0);
                n_sda_low = ~n_quarter[1];
            end
            default: ;
        endcase
    end

    // NOTE: the payload bytes carry no reset; they are always written on
    // acceptance before anything reads them, so a reset would only add logic.
    always_ff @(posedge clock_50) begin
        if (state == S_IDLE && start) begin
            tx_byte <= {reg_data, reg_addr, device_addr};
        end
    end

    always_ff @(posedge clock_50) begin
        // NOTE: state registers use non-blocking assignments so every
        // register samples the values from before this edge.
        if (reset) begin
            state     <= S_IDLE;
            qcnt      <= '0;
            quarter   <= 2'd0;
            bit_idx   <= 4'd0;
            byte_idx  <= 2'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            ack_error <= 1'b0;
            scl_low   <= 1'b0;
            sda_low   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == S_IDLE) begin
                if (start) begin
                    state     <= S_START;
                    busy      <= 1'b1;
                    ack_error <= 1'b0;
                    // The accepting cycle is already the first clock of
                    // START q0, so the counter continues from 1.
                    qcnt      <= QW'(1);
                    quarter   <= 2'd0;
                    bit_idx   <= 4'd0;
                    byte_idx  <= 2'd0;
                    scl_low   <= 1'b0;
                    sda_low   <= 1'b0;
                end
            end else if (tick) begin
                qcnt     <= '0;
                state    <= n_state;
                quarter  <= n_quarter;
                bit_idx  <= n_bit_idx;
                byte_idx <= n_byte_idx;
                scl_low  <= n_scl_low;
                sda_low  <= n_sda_low;
                // Sample the slave's answer at the end of ACK q2 (SCL high).
                if (state == S_BIT && bit_idx == 4'd8 && quarter == 2'd2 &&
                    i2c_serial_data) begin
                    ack_error <= 1'b1;
                end
                if (n_last) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end else begin
                qcnt <= qcnt + QW'(1);
            end
        end
    end

    assign i2c_serial_clock = scl_low ? 1'b0 : 1'bz;
    assign i2c_serial_data  = sda_low ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_reg_writer.sv
// Testbench for i2c_reg_writer at Q = 2 (800 kHz clock, 100 kHz SCL).
// A slave model on the open-drain bus decodes bytes, detects START/STOP and
// ACKs or NACKs per byte. Each request pushes its expected completion into a
// scoreboard queue; a monitor pops and compares whenever done pulses.
module tb_i2c_reg_writer;
    localparam int CLK_HZ = 800_000;
    localparam int I2C_HZ = 100_000;
    localparam int Q      = CLK_HZ / (4 * I2C_HZ);

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] device_addr, reg_addr, reg_data;
    logic       busy, done, ack_error;
    wire        scl, sda;

    pullup (scl);
    pullup (sda);

    logic slave_sda_low = 1'b0;
    assign sda = slave_sda_low ? 1'b0 : 1'bz;

    i2c_reg_writer #(.CLK_HZ(CLK_HZ), .I2C_HZ(I2C_HZ)) dut (
        .clock_50        (clk),
        .reset           (reset),
        .start           (start),
        .device_addr     (device_addr),
        .reg_addr        (reg_addr),
        .reg_data        (reg_data),
        .busy            (busy),
        .done            (done),
        .ack_error       (ack_error),
        .i2c_serial_clock(scl),
        .i2c_serial_data (sda)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        int          due;      // absolute cyc value at which done must show
        logic        aerr;
        int          nbytes;
        logic [23:0] bytes;    // first decoded byte in the top 8 bits
    } exp_t;

    exp_t exp_q[$];
    int   t0;

    // ---------------- slave model ----------------
    logic [2:0] nack_mask = 3'b000;   // bit k set: NACK byte k
    logic       prev_scl = 1'b1, prev_sda = 1'b1;
    int         bitcnt = 0;
    int         byte_no = 0;
    logic       in_ack = 1'b0;
    logic [7:0] shreg = 8'h00;
    logic [7:0] got_q[$];
    logic       got_start = 1'b0, got_stop = 1'b0;

    always @(negedge clk) begin
        logic cs, cd;
        cs = scl;
        cd = sda;
        if (prev_scl && cs && prev_sda && !cd) begin
            got_start     = 1'b1;
            got_stop      = 1'b0;
            got_q.delete();
            bitcnt        = 0;
            byte_no       = 0;
            in_ack        = 1'b0;
            slave_sda_low = 1'b0;
        end else if (prev_scl && cs && !prev_sda && cd) begin
            got_stop = 1'b1;
        end else if (!prev_scl && cs) begin
            if (!in_ack && bitcnt < 8) begin
                shreg  = {shreg[6:0], cd};
                bitcnt = bitcnt + 1;
            end
        end else if (prev_scl && !cs) begin
            if (in_ack) begin
                in_ack        = 1'b0;
                slave_sda_low = 1'b0;
                bitcnt        = 0;
                byte_no       = byte_no + 1;
            end else if (bitcnt == 8) begin
                in_ack = 1'b1;
                got_q.push_back(shreg);
                slave_sda_low = (byte_no < 3) ? !nack_mask[byte_no] : 1'b0;
            end
        end
        prev_scl = cs;
        prev_sda = cd;
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!reset && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("done_cycle", cyc, e.due);
                check("ack_error", {31'd0, ack_error}, {31'd0, e.aerr});
                check("busy_at_done", {31'd0, busy}, 32'd0);
                check("start_stop_seen", {30'd0, got_start, got_stop}, 32'd3);
                check("byte_count", got_q.size(), e.nbytes);
                for (int i = 0; i < e.nbytes && i < got_q.size(); i++) begin
                    check($sformatf("byte%0d", i), {24'd0, got_q[i]}, {24'd0, e.bytes[23-8*i -: 8]});
                end
                got_start = 1'b0;
                got_stop  = 1'b0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_write(input logic [7:0] d, input logic [7:0] r, input logic [7:0] v,
                            input logic [2:0] mask, input int nbytes, input int dur,
                            input logic aerr);
        exp_t e;
        @(negedge clk);
        device_addr = d;
        reg_addr    = r;
        reg_data    = v;
        nack_mask   = mask;
        start       = 1'b1;
        t0          = cyc;
        e.due       = t0 + dur;
        e.aerr      = aerr;
        e.nbytes    = nbytes;
        e.bytes     = {d, r, v};
        exp_q.push_back(e);
        @(negedge clk);
        start       = 1'b0;
        // Inputs may change once accepted; the latched bytes must be used.
        device_addr = ~d;
        reg_addr    = ~r;
        reg_data    = ~v;
        check("accept_busy", {31'd0, busy}, 32'd1);
        check("accept_aerr_clear", {31'd0, ack_error}, 32'd0);
    endtask

    task automatic wait_done(input int limit);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            check("done_timeout", 32'd1, 32'd0);
            exp_q.delete();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        device_addr = 8'h00;
        reg_addr    = 8'h00;
        reg_data    = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state held for 20 idle cycles.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("reset_idle", {27'd0, busy, done, ack_error, scl, sda}, 32'b00011);
        end

        // Clean write, every byte ACKed: 116 quarters.
        do_write(8'h72, 8'h98, 8'h03, 3'b000, 3, 116 * Q, 1'b0);
        wait_done(400);

        // Device address NACKed: only byte 0 goes out, 44 quarters.
        do_write(8'h72, 8'h98, 8'h03, 3'b001, 1, 44 * Q, 1'b1);
        wait_done(400);
        repeat (3) @(negedge clk);
        check("aerr_held", {31'd0, ack_error}, 32'd1);

        // reg_data NACKed: full length, error flagged.
        do_write(8'h72, 8'h98, 8'h03, 3'b100, 3, 116 * Q, 1'b1);
        wait_done(400);

        // Clean write clears the error on acceptance.
        do_write(8'h72, 8'h0F, 8'hF0, 3'b000, 3, 116 * Q, 1'b0);
        wait_done(400);

        // start pulses inside a transaction must be ignored.
        do_write(8'hA5, 8'h5A, 8'h81, 3'b000, 3, 116 * Q, 1'b0);
        while (cyc - t0 < 5) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (cyc - t0 < 100) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(400);
        repeat (300) @(negedge clk);

        // Reset mid-transaction: pins release, busy drops, no done.
        do_write(8'h72, 8'h98, 8'h03, 3'b000, 3, 116 * Q, 1'b0);
        while (cyc - t0 < 60) @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("midreset_release", {29'd0, busy, scl, sda}, 32'b011);
        check("midreset_no_done", {31'd0, done}, 32'd0);
        reset = 1'b0;
        repeat (240) @(negedge clk);

        // A fresh write after the abort completes normally.
        do_write(8'h3C, 8'hC3, 8'h55, 3'b000, 3, 116 * Q, 1'b0);
        wait_done(400);
        repeat (10) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
